// File: rtl/bus_arbiter.sv
// Two-master, three-slave bus arbiter with split-transaction parking
// and a per-tenure bus-hold watchdog.
module bus_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int MAX_COUNT = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    input  logic [2:0]           s_split_en,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 arbiter_busy,
    output logic                 bus_busy,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 timeout
);

    localparam int CW = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        BUSY
    } state_t;

    state_t               state;
    logic                 win_m2;
    logic                 last_m2;
    logic [1:0]           split_pending;
    logic [SLAVE_LEN-1:0] split_slave [2];
    logic [CW-1:0]        cnt;

    logic elig1;
    logic elig2;
    logic pick_m2;
    logic gnt_req;
    logic cur_split;

    // Split line of slave number sel (1..3); no slave for other codes.
    function automatic logic split_hit(
        input logic [SLAVE_LEN-1:0] sel,
        input logic [2:0]           en
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (int'(sel) == i + 1) hit = en[i];
        end
        return hit;
    endfunction

    // Eligibility and winner choice; parked masters go first.
    always_comb begin
        elig1 = m1_request && (m1_slave_sel != '0)
              && !(split_pending[0] && split_hit(split_slave[0], s_split_en))
              && !(split_pending[1] && m1_slave_sel == split_slave[1]);
        elig2 = m2_request && (m2_slave_sel != '0)
              && !(split_pending[1] && split_hit(split_slave[1], s_split_en))
              && !(split_pending[0] && m2_slave_sel == split_slave[0]);
        if (elig1 && split_pending[0])      pick_m2 = 1'b0;
        else if (elig2 && split_pending[1]) pick_m2 = 1'b1;
        else if (elig1 && elig2)            pick_m2 = !last_m2;
        else                                pick_m2 = elig2;
        gnt_req   = win_m2 ? m2_request : m1_request;
        cur_split = split_hit(slave_sel, s_split_en);
    end

    // Arbitration FSM with registered grant/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            win_m2         <= 1'b0;
            last_m2        <= 1'b1;
            split_pending  <= '0;
            split_slave[0] <= '0;
            split_slave[1] <= '0;
            cnt            <= '0;
            m1_grant       <= 1'b0;
            m2_grant       <= 1'b0;
            arbiter_busy   <= 1'b0;
            bus_busy       <= 1'b0;
            slave_sel      <= '0;
            timeout        <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (elig1 || elig2) begin
                        state        <= ARB;
                        win_m2       <= pick_m2;
                        m1_grant     <= !pick_m2;
                        m2_grant     <= pick_m2;
                        arbiter_busy <= 1'b1;
                        slave_sel    <= pick_m2 ? m2_slave_sel
                                                : m1_slave_sel;
                    end
                end
                ARB: begin
                    state                 <= BUSY;
                    bus_busy              <= 1'b1;
                    cnt                   <= '0;
                    split_pending[win_m2] <= 1'b0;
                    split_slave[win_m2]   <= '0;
                end
                BUSY: begin
                    if (trans_done || !gnt_req || cur_split
                        || cnt == CNT_LAST) begin
                        state        <= IDLE;
                        m1_grant     <= 1'b0;
                        m2_grant     <= 1'b0;
                        arbiter_busy <= 1'b0;
                        bus_busy     <= 1'b0;
                        slave_sel    <= '0;
                    end
                    if (trans_done || !gnt_req) begin
                        last_m2 <= win_m2;
                    end else if (cur_split) begin
                        split_pending[win_m2] <= 1'b1;
                        split_slave[win_m2]   <= slave_sel;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        last_m2 <= win_m2;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (!m1_request) begin
                split_pending[0] <= 1'b0;
                split_slave[0]   <= '0;
            end
            if (!m2_request) begin
                split_pending[1] <= 1'b0;
                split_slave[1]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a tenure-level model predicts
// every cycle's outputs; a monitor compares them after each edge.
module tb_bus_arbiter;

    localparam int MAXC = 8;

    logic       clk;
    logic       rst;
    logic       m1_request;
    logic       m2_request;
    logic [1:0] m1_slave_sel;
    logic [1:0] m2_slave_sel;
    logic       trans_done;
    logic [2:0] s_split_en;
    logic       m1_grant;
    logic       m2_grant;
    logic       arbiter_busy;
    logic       bus_busy;
    logic [1:0] slave_sel;
    logic       timeout;

    bus_arbiter #(
        .SLAVE_LEN(2),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m1_request  (m1_request),
        .m2_request  (m2_request),
        .m1_slave_sel(m1_slave_sel),
        .m2_slave_sel(m2_slave_sel),
        .trans_done  (trans_done),
        .s_split_en  (s_split_en),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .arbiter_busy(arbiter_busy),
        .bus_busy    (bus_busy),
        .slave_sel   (slave_sel),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] exp_q[$];

    // Model: bus owner (0 none, 1 = M1, 2 = M2), age of the tenure
    // in cycles since grant, owner's slave, and parked-split records.
    int own    = 0;
    int age    = 0;
    int msel   = 0;
    int last   = 2;
    bit rec    [3];
    int rslave [3];
    int model_to = 0;
    int model_gr = 0;
    int dut_to   = 0;
    int dut_gr   = 0;

    function automatic bit spbit(input logic [2:0] sp, input int s);
        if (s >= 1 && s <= 3) return sp[s-1];
        return 1'b0;
    endfunction

    task automatic model_step();
        int req [3];
        int sel [3];
        bit el  [3];
        bit to;
        int w;
        to     = 1'b0;
        req[1] = int'(m1_request);
        req[2] = int'(m2_request);
        sel[1] = int'(m1_slave_sel);
        sel[2] = int'(m2_slave_sel);
        if (!rst) begin
            own = 0; age = 0; msel = 0; last = 2;
            for (int m = 1; m <= 2; m++) begin
                rec[m] = 1'b0; rslave[m] = 0;
            end
        end else begin
            if (own == 0) begin
                for (int m = 1; m <= 2; m++) begin
                    el[m] = req[m] != 0 && sel[m] != 0
                          && !(rec[m] && spbit(s_split_en, rslave[m]))
                          && !(rec[3-m] && sel[m] == rslave[3-m]);
                end
                w = 0;
                if (el[1] && rec[1])      w = 1;
                else if (el[2] && rec[2]) w = 2;
                else if (el[1] && el[2])  w = 3 - last;
                else if (el[1])           w = 1;
                else if (el[2])           w = 2;
                if (w != 0) begin
                    own = w; msel = sel[w]; age = 0;
                    model_gr++;
                end
            end else if (age == 0) begin
                rec[own] = 1'b0; rslave[own] = 0; age = 1;
            end else if (trans_done || req[own] == 0) begin
                last = own; own = 0;
            end else if (spbit(s_split_en, msel)) begin
                rec[own] = 1'b1; rslave[own] = msel; own = 0;
            end else if (age == MAXC) begin
                to = 1'b1; last = own; own = 0;
                model_to++;
            end else begin
                age++;
            end
            for (int m = 1; m <= 2; m++) begin
                if (req[m] == 0) begin
                    rec[m] = 1'b0; rslave[m] = 0;
                end
            end
        end
        exp_q.push_back({own == 1, own == 2, own != 0,
                         own != 0 && age >= 1,
                         own != 0 ? 2'(msel) : 2'd0, to});
    endtask

    task automatic step(input logic r, input logic q1,
                        input logic [1:0] a1, input logic q2,
                        input logic [1:0] a2, input logic td,
                        input logic [2:0] sp);
        rst          = r;
        m1_request   = q1;
        m1_slave_sel = a1;
        m2_request   = q2;
        m2_slave_sel = a2;
        trans_done   = td;
        s_split_en   = sp;
        model_step();
        @(negedge clk);
    endtask

    // Monitor: compare every output after each rising edge.
    logic [6:0] got;
    logic [6:0] want;
    logic       pg1 = 1'b0;
    logic       pg2 = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {m1_grant, m2_grant, arbiter_busy, bus_busy,
                    slave_sel, timeout};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cyc=%0d got g1g2 ab bb sel to=%b required=%b",
                         cyc, got, want);
            end
            checks++;
            if (m1_grant && m2_grant) begin
                errors++;
                $display("FAIL both_grants cyc=%0d got=11 required=not both",
                         cyc);
            end
            if (timeout) dut_to++;
            if ((m1_grant && !pg1) || (m2_grant && !pg2)) dut_gr++;
        end
        pg1 = m1_grant;
        pg2 = m2_grant;
    end

    logic       rq1, rq2, rtd, rr;
    logic [1:0] ra1, ra2;
    logic [2:0] rsp;

    initial begin
        rst = 1'b0; m1_request = 1'b0; m2_request = 1'b0;
        m1_slave_sel = '0; m2_slave_sel = '0;
        trans_done = 1'b0; s_split_en = '0;
        @(negedge clk);
        // reset state
        step(0, 0, 0, 0, 0, 0, 3'b000);
        step(0, 1, 2, 1, 1, 1, 3'b111);
        // single request then done
        step(1, 0, 0, 0, 0, 0, 3'b000);
        step(1, 1, 2, 0, 0, 0, 3'b000);
        step(1, 1, 2, 0, 0, 0, 3'b000);
        step(1, 1, 2, 0, 0, 0, 3'b000);
        step(1, 1, 2, 0, 0, 1, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // round-robin, done every 5 cycles
        for (int i = 1; i <= 25; i++)
            step(1, 1, 1, 1, 2, (i % 5) == 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // split: M1 on slave 3 parks, M2 served, then M1 regranted
        for (int i = 0; i < 3; i++) step(1, 1, 3, 0, 0, 0, 3'b000);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 1, 1, 0, 3'b100);
        step(1, 1, 3, 1, 1, 1, 3'b100);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 1, 3, 0, 3'b100);
        for (int i = 0; i < 3; i++) step(1, 1, 3, 1, 3, 0, 3'b000);
        step(1, 1, 3, 1, 3, 1, 3'b000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 3'b000);
        step(1, 0, 0, 1, 1, 1, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // watchdog: M2 holds the bus, M1 waits
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 3'b000);
        for (int i = 0; i < 24; i++) step(1, 1, 2, 1, 1, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // done and split together
        for (int i = 0; i < 3; i++) step(1, 1, 3, 0, 0, 0, 3'b000);
        step(1, 1, 3, 1, 3, 1, 3'b100);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 3, 0, 3'b100);
        step(1, 0, 0, 1, 3, 1, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // slave_sel 0 never granted
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0, 3'b000);
        // reset mid-tenure with M1 record set
        for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0, 0, 3'b000);
        step(1, 1, 2, 1, 1, 0, 3'b010);
        for (int i = 0; i < 3; i++) step(1, 1, 2, 1, 1, 0, 3'b010);
        step(0, 1, 2, 1, 1, 0, 3'b010);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 3'b000);
        // random traffic
        rq1 = 0; rq2 = 0; ra1 = 1; ra2 = 2; rsp = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) rq1 = !rq1;
            if ($urandom_range(0, 9) == 0) rq2 = !rq2;
            if ($urandom_range(0, 7) == 0) ra1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
                rsp = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            rtd = ($urandom_range(0, 6) == 0);
            rr  = ($urandom_range(0, 199) != 0);
            step(rr, rq1, ra1, rq2, ra2, rtd, rsp);
        end
        step(1, 0, 0, 0, 0, 0, 3'b000);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        checks++;
        if (dut_to != model_to) begin
            errors++;
            $display("FAIL timeout_count got=%0d required=%0d",
                     dut_to, model_to);
        end
        checks++;
        if (dut_gr != model_gr) begin
            errors++;
            $display("FAIL grant_count got=%0d required=%0d",
                     dut_gr, model_gr);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
